// File: rtl/cix32_muldiv_arb_if.sv
// Bundle of the two requester ports, the shared response payload and the mul/div unit port.
// The arbiter takes the slave view; requesters and the unit together take the master view.
interface cix32_muldiv_arb_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_is_div;
  logic [1:0]       req_is_signed;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_op_a;
  logic [1:0][31:0] req_op_b;
  logic [1:0][31:0] req_op_high;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [63:0]      rsp_result;
  logic             rsp_div_err;
  logic             rsp_timeout;
  logic             rsp_cf;
  logic             rsp_of;

  logic             md_start;
  logic             md_is_div;
  logic             md_is_signed;
  logic             md_is_8bit;
  logic             md_is_16bit;
  logic [31:0]      md_op_a;
  logic [31:0]      md_op_b;
  logic [31:0]      md_op_high;
  logic [63:0]      md_result;
  logic             md_ready;
  logic             md_divide_error;
  logic             md_cf;
  logic             md_of;

  modport slave (
    input  req_valid, req_is_div, req_is_signed, req_size, req_op_a, req_op_b, req_op_high,
    output req_ready,
    output rsp_valid, rsp_result, rsp_div_err, rsp_timeout, rsp_cf, rsp_of,
    input  rsp_ready,
    output md_start, md_is_div, md_is_signed, md_is_8bit, md_is_16bit,
    output md_op_a, md_op_b, md_op_high,
    input  md_result, md_ready, md_divide_error, md_cf, md_of
  );

  modport master (
    output req_valid, req_is_div, req_is_signed, req_size, req_op_a, req_op_b, req_op_high,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_div_err, rsp_timeout, rsp_cf, rsp_of,
    output rsp_ready,
    input  md_start, md_is_div, md_is_signed, md_is_8bit, md_is_16bit,
    input  md_op_a, md_op_b, md_op_high,
    output md_result, md_ready, md_divide_error, md_cf, md_of
  );
endinterface

// File: rtl/cix32_muldiv_arb.sv
// Round-robin arbiter sharing one multiply/divide unit between the pipeline (0) and
// microcode (1), with a watchdog that aborts an operation the unit never completes.
module cix32_muldiv_arb #(
  parameter int unsigned WDOG_CYCLES = 48
) (
  input logic               clk,
  input logic               rst,
  cix32_muldiv_arb_if.slave bus
);

  localparam int unsigned CntW = 6;
  localparam logic [CntW-1:0] WdogLast = CntW'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StResp,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic            last_grant_q;
  logic            id_q;
  logic            is_div_q;
  logic            is_signed_q;
  logic [1:0]      size_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic [31:0]     op_high_q;

  logic [CntW-1:0] wdog_q, wdog_d;

  logic [63:0]     res_q, res_d;
  logic            div_err_q, div_err_d;
  logic            timeout_q, timeout_d;
  logic            cf_q, cf_d;
  logic            of_q, of_d;

  logic            grant_id;
  logic [1:0]      req_ready;
  logic            accept;
  logic            md_start;
  logic [1:0]      rsp_valid;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    grant_id = 1'b0;
    unique case (bus.req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && !rst && (|bus.req_valid)) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      is_div_q     <= 1'b0;
      is_signed_q  <= 1'b0;
      size_q       <= 2'b00;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_high_q    <= '0;
    end else if (accept) begin
      last_grant_q <= grant_id;
      id_q         <= grant_id;
      is_div_q     <= bus.req_is_div[grant_id];
      is_signed_q  <= bus.req_is_signed[grant_id];
      size_q       <= bus.req_size[grant_id];
      op_a_q       <= bus.req_op_a[grant_id];
      op_b_q       <= bus.req_op_b[grant_id];
      op_high_q    <= bus.req_op_high[grant_id];
    end
  end

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    res_d     = res_q;
    div_err_d = div_err_q;
    timeout_d = timeout_q;
    cf_d      = cf_q;
    of_d      = of_q;
    md_start  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        md_start = 1'b1;
        state_d  = StGuard;
      end
      // The unit may still show ready from a previous op here, so it is not sampled.
      StGuard: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.md_ready) begin
          res_d     = bus.md_result;
          div_err_d = is_div_q & bus.md_divide_error;
          timeout_d = 1'b0;
          cf_d      = ~is_div_q & bus.md_cf;
          of_d      = ~is_div_q & bus.md_of;
          state_d   = StResp;
        end else if (wdog_q == WdogLast) begin
          res_d     = '0;
          div_err_d = 1'b0;
          timeout_d = 1'b1;
          cf_d      = 1'b0;
          of_d      = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready[id_q]) state_d = StDrain;
      end
      // Second start pulse returns the unit to idle before the next grant.
      StDrain: begin
        md_start = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wdog_q    <= '0;
      res_q     <= '0;
      div_err_q <= 1'b0;
      timeout_q <= 1'b0;
      cf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      res_q     <= res_d;
      div_err_q <= div_err_d;
      timeout_q <= timeout_d;
      cf_q      <= cf_d;
      of_q      <= of_d;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StResp) rsp_valid[id_q] = 1'b1;
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_div_err  = div_err_q;
  assign bus.rsp_timeout  = timeout_q;
  assign bus.rsp_cf       = cf_q;
  assign bus.rsp_of       = of_q;

  assign bus.md_start     = md_start;
  assign bus.md_is_div    = is_div_q;
  assign bus.md_is_signed = is_signed_q;
  assign bus.md_is_8bit   = (size_q == 2'b10);
  assign bus.md_is_16bit  = (size_q == 2'b01);
  assign bus.md_op_a      = op_a_q;
  assign bus.md_op_b      = op_b_q;
  assign bus.md_op_high   = op_high_q;

endmodule

// File: tb/tb_cix32_muldiv_arb.sv
// Directed bench for cix32_muldiv_arb with a simple unsigned mul/div unit model.
module tb_cix32_muldiv_arb;

  localparam int unsigned Wdog = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   unit_lat = 3;
  bit   unit_hang = 1'b0;

  cix32_muldiv_arb_if bus ();

  cix32_muldiv_arb #(
    .WDOG_CYCLES(Wdog)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Unit model: unsigned only; drives junk on flags the arbiter must mask.
  logic        u_busy;
  int          u_cnt;
  logic [63:0] u_prod, u_dvd, u_dsr, u_q64, u_r64;

  assign u_prod = {32'b0, bus.md_op_a} * {32'b0, bus.md_op_b};
  assign u_dvd  = {bus.md_op_high, bus.md_op_a};
  assign u_dsr  = {32'b0, (bus.md_op_b == 32'd0) ? 32'd1 : bus.md_op_b};
  assign u_q64  = u_dvd / u_dsr;
  assign u_r64  = u_dvd % u_dsr;

  always @(posedge clk) begin
    if (rst) begin
      u_busy              <= 1'b0;
      u_cnt               <= 0;
      bus.md_ready        <= 1'b0;
      bus.md_result       <= '0;
      bus.md_divide_error <= 1'b0;
      bus.md_cf           <= 1'b0;
      bus.md_of           <= 1'b0;
    end else if (bus.md_start) begin
      if (u_busy) begin
        u_busy       <= 1'b0;
        bus.md_ready <= 1'b0;
      end else begin
        u_busy       <= 1'b1;
        u_cnt        <= unit_lat;
        bus.md_ready <= 1'b0;
        if (bus.md_is_div) begin
          bus.md_cf <= 1'b1;
          bus.md_of <= 1'b1;
          if (bus.md_op_b == 32'd0) begin
            bus.md_result       <= '0;
            bus.md_divide_error <= 1'b1;
          end else begin
            bus.md_result       <= {u_r64[31:0], u_q64[31:0]};
            bus.md_divide_error <= 1'b0;
          end
        end else begin
          bus.md_result       <= u_prod;
          bus.md_divide_error <= 1'b1;
          bus.md_cf           <= |u_prod[63:32];
          bus.md_of           <= |u_prod[63:32];
        end
      end
    end else if (u_busy && !bus.md_ready && !unit_hang) begin
      if (u_cnt <= 1) bus.md_ready <= 1'b1;
      else u_cnt <= u_cnt - 1;
    end
  end

  // Presents a request and returns at the negedge of the ISSUE cycle.
  task automatic send(input int id, input bit div, input bit [1:0] size,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] high,
                      output bit ok);
    ok = 1'b0;
    bus.req_is_div[id]    = div;
    bus.req_is_signed[id] = 1'b0;
    bus.req_size[id]      = size;
    bus.req_op_a[id]      = a;
    bus.req_op_b[id]      = b;
    bus.req_op_high[id]   = high;
    bus.req_valid[id]     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  // Negedges until rsp_valid is seen; -1 if the bound expires.
  task automatic wait_rsp(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.rsp_valid != 2'b00) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_rsp(input int id);
    bus.rsp_ready[id] = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready !== 2'b00) begin bad++;
      $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++;
      $display("FAIL reset_rsp_valid got=%b want=00", bus.rsp_valid); end
    total++; if (bus.md_start !== 1'b0) begin bad++;
      $display("FAIL reset_md_start got=%b want=0", bus.md_start); end
    total++; if (bus.rsp_result !== 64'd0) begin bad++;
      $display("FAIL reset_rsp_result got=%h want=0", bus.rsp_result); end
    total++; if ({bus.rsp_div_err, bus.rsp_timeout, bus.rsp_cf, bus.rsp_of} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000",
        {bus.rsp_div_err, bus.rsp_timeout, bus.rsp_cf, bus.rsp_of}); end
    total++; if (bus.md_op_a !== 32'd0) begin bad++;
      $display("FAIL reset_md_op_a got=%h want=0", bus.md_op_a); end
    bus.req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul;
    bit ok;
    int n;
    send(0, 1'b0, 2'b00, 32'd7, 32'd6, 32'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL mul_grant got=none want=granted"); end
    total++; if (bus.md_start !== 1'b1) begin bad++;
      $display("FAIL mul_start_issue got=%b want=1", bus.md_start); end
    bus.req_op_a[0] = 32'd99;
    @(negedge clk);
    total++; if (bus.md_start !== 1'b0) begin bad++;
      $display("FAIL mul_start_guard got=%b want=0", bus.md_start); end
    total++; if (bus.md_op_a !== 32'd7) begin bad++;
      $display("FAIL mul_op_stable got=%0d want=7", bus.md_op_a); end
    wait_rsp(40, n);
    total++; if (n != unit_lat + 1) begin bad++;
      $display("FAIL mul_latency got=%0d want=%0d", n, unit_lat + 1); end
    total++; if (bus.rsp_valid !== 2'b01) begin bad++;
      $display("FAIL mul_rsp_valid got=%b want=01", bus.rsp_valid); end
    total++; if (bus.rsp_result !== 64'd42) begin bad++;
      $display("FAIL mul_result got=%0d want=42", bus.rsp_result); end
    total++; if ({bus.rsp_cf, bus.rsp_of, bus.rsp_div_err} !== 3'b000) begin bad++;
      $display("FAIL mul_flags got=%b want=000", {bus.rsp_cf, bus.rsp_of, bus.rsp_div_err}); end
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    total++; if (bus.md_start !== 1'b1 || bus.rsp_valid !== 2'b00) begin bad++;
      $display("FAIL mul_drain got=start%b/valid%b want=start1/valid00",
        bus.md_start, bus.rsp_valid); end
    @(negedge clk);
    total++; if (bus.md_start !== 1'b0) begin bad++;
      $display("FAIL mul_idle_start got=%b want=0", bus.md_start); end
  endtask

  task automatic test_div;
    bit ok;
    int n;
    send(1, 1'b1, 2'b00, 32'd100, 32'd7, 32'd0, ok);
    wait_rsp(40, n);
    total++; if (!ok || n != unit_lat + 2) begin bad++;
      $display("FAIL div_latency got=%0d want=%0d", n, unit_lat + 2); end
    total++; if (bus.rsp_valid !== 2'b10) begin bad++;
      $display("FAIL div_rsp_valid got=%b want=10", bus.rsp_valid); end
    total++; if (bus.rsp_result !== {32'd2, 32'd14}) begin bad++;
      $display("FAIL div_result got=%h want=%h", bus.rsp_result, {32'd2, 32'd14}); end
    total++; if ({bus.rsp_div_err, bus.rsp_cf, bus.rsp_of} !== 3'b000) begin bad++;
      $display("FAIL div_flags got=%b want=000", {bus.rsp_div_err, bus.rsp_cf, bus.rsp_of}); end
    take_rsp(1);

    send(0, 1'b1, 2'b00, 32'd5, 32'd0, 32'd0, ok);
    wait_rsp(40, n);
    total++; if (bus.rsp_valid !== 2'b01) begin bad++;
      $display("FAIL div0_rsp_valid got=%b want=01", bus.rsp_valid); end
    total++; if (bus.rsp_div_err !== 1'b1 || bus.rsp_timeout !== 1'b0) begin bad++;
      $display("FAIL div0_flags got=err%b/to%b want=err1/to0",
        bus.rsp_div_err, bus.rsp_timeout); end
    take_rsp(0);
  endtask

  task automatic test_size_overflow;
    bit ok;
    int n;
    send(1, 1'b0, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd0, ok);
    total++; if ({bus.md_is_16bit, bus.md_is_8bit} !== 2'b10) begin bad++;
      $display("FAIL size16_decode got=%b want=10", {bus.md_is_16bit, bus.md_is_8bit}); end
    wait_rsp(40, n);
    total++; if (bus.rsp_result !== 64'h1_0000_0000) begin bad++;
      $display("FAIL ovf_result got=%h want=100000000", bus.rsp_result); end
    total++; if ({bus.rsp_cf, bus.rsp_of, bus.rsp_div_err} !== 3'b110) begin bad++;
      $display("FAIL ovf_flags got=%b want=110", {bus.rsp_cf, bus.rsp_of, bus.rsp_div_err}); end
    take_rsp(1);

    send(0, 1'b0, 2'b10, 32'd3, 32'd5, 32'd0, ok);
    total++; if ({bus.md_is_16bit, bus.md_is_8bit} !== 2'b01) begin bad++;
      $display("FAIL size8_decode got=%b want=01", {bus.md_is_16bit, bus.md_is_8bit}); end
    wait_rsp(40, n);
    take_rsp(0);

    send(0, 1'b0, 2'b11, 32'd3, 32'd5, 32'd0, ok);
    total++; if ({bus.md_is_16bit, bus.md_is_8bit} !== 2'b00) begin bad++;
      $display("FAIL size_rsvd_decode got=%b want=00", {bus.md_is_16bit, bus.md_is_8bit}); end
    wait_rsp(40, n);
    take_rsp(0);
  endtask

  task automatic test_round_robin;
    int ng = 0;
    int dbl = 0;
    logic [3:0] order = 4'b0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req_is_div = 2'b00;
    bus.req_size = '0;
    bus.req_op_a[0] = 32'd2; bus.req_op_b[0] = 32'd3;
    bus.req_op_a[1] = 32'd4; bus.req_op_b[1] = 32'd5;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 100 && ng < 4; i++) begin
      #1;
      if (bus.req_ready == 2'b11) dbl++;
      if (bus.req_ready != 2'b00) begin
        order[ng] = bus.req_ready[1];
        ng++;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    repeat (unit_lat + 6) @(negedge clk);
    bus.rsp_ready = 2'b00;
    total++; if (ng != 4) begin bad++; $display("FAIL rr_grant_count got=%0d want=4", ng); end
    total++; if (dbl != 0) begin bad++; $display("FAIL rr_double_ready got=%0d want=0", dbl); end
    total++; if (order !== 4'b1010) begin bad++;
      $display("FAIL rr_order got=%b want=1010 (lsb first)", order); end
  endtask

  task automatic test_back_to_back;
    int g0 = -1;
    int g1 = -1;
    int r0 = -1;
    bus.req_is_div[0] = 1'b0;
    bus.req_size[0] = 2'b00;
    bus.req_op_a[0] = 32'd10;
    bus.req_op_b[0] = 32'd10;
    bus.rsp_ready[0] = 1'b1;
    bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 60 && g1 < 0; i++) begin
      #1;
      if (bus.req_ready[0]) begin
        if (g0 < 0) g0 = i;
        else g1 = i;
      end
      if (bus.rsp_valid[0] && r0 < 0) r0 = i;
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    repeat (unit_lat + 6) @(negedge clk);
    bus.rsp_ready = 2'b00;
    total++; if (g0 < 0 || r0 - g0 != unit_lat + 3) begin bad++;
      $display("FAIL b2b_latency got=%0d want=%0d", r0 - g0, unit_lat + 3); end
    total++; if (g1 < 0 || g1 - g0 != unit_lat + 5) begin bad++;
      $display("FAIL b2b_period got=%0d want=%0d", g1 - g0, unit_lat + 5); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    unit_hang = 1'b1;
    send(0, 1'b0, 2'b00, 32'd1, 32'd2, 32'd0, ok);
    wait_rsp(Wdog + 20, n);
    total++; if (!ok || n != Wdog + 2) begin bad++;
      $display("FAIL timeout_cycles got=%0d want=%0d", n, Wdog + 2); end
    total++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_result !== 64'd0) begin bad++;
      $display("FAIL timeout_payload got=to%b/res%h want=to1/res0",
        bus.rsp_timeout, bus.rsp_result); end
    total++; if ({bus.rsp_div_err, bus.rsp_cf, bus.rsp_of} !== 3'b000) begin bad++;
      $display("FAIL timeout_flags got=%b want=000", {bus.rsp_div_err, bus.rsp_cf, bus.rsp_of}); end
    take_rsp(0);
    unit_hang = 1'b0;

    // Unit answers in the last WAIT cycle: completion beats the watchdog.
    unit_lat = Wdog;
    send(1, 1'b0, 2'b00, 32'd3, 32'd4, 32'd0, ok);
    wait_rsp(Wdog + 20, n);
    total++; if (n != Wdog + 2) begin bad++;
      $display("FAIL race_cycles got=%0d want=%0d", n, Wdog + 2); end
    total++; if (bus.rsp_timeout !== 1'b0 || bus.rsp_result !== 64'd12) begin bad++;
      $display("FAIL race_payload got=to%b/res%0d want=to0/res12",
        bus.rsp_timeout, bus.rsp_result); end
    take_rsp(1);
    unit_lat = 3;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    int stale = 0;
    int unstable = 0;
    unit_lat = 10;
    send(0, 1'b0, 2'b00, 32'd5, 32'd5, 32'd0, ok);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.md_op_a !== 32'd0) begin bad++;
      $display("FAIL rstmid_op_cleared got=%0d want=0", bus.md_op_a); end
    rst = 1'b0;
    unit_lat = 3;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) stale++;
    end
    total++; if (stale != 0) begin bad++;
      $display("FAIL rstmid_stale_rsp got=%0d want=0", stale); end
    send(1, 1'b0, 2'b00, 32'd9, 32'd11, 32'd0, ok);
    wait_rsp(40, n);
    total++; if (!ok || n != unit_lat + 2) begin bad++;
      $display("FAIL rstmid_latency got=%0d want=%0d", n, unit_lat + 2); end
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 64'd99) begin bad++;
      $display("FAIL rstmid_rsp got=v%b/res%0d want=v10/res99", bus.rsp_valid, bus.rsp_result); end
    bus.rsp_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 64'd99) unstable++;
    end
    bus.rsp_ready = 2'b00;
    total++; if (unstable != 0) begin bad++;
      $display("FAIL rstmid_hold got=%0d unstable want=0", unstable); end
    take_rsp(1);
    total++; if (bus.rsp_valid !== 2'b00) begin bad++;
      $display("FAIL rstmid_release got=%b want=00", bus.rsp_valid); end
  endtask

  initial begin
    bus.req_valid     = 2'b00;
    bus.req_is_div    = 2'b00;
    bus.req_is_signed = 2'b00;
    bus.req_size      = '0;
    bus.req_op_a      = '0;
    bus.req_op_b      = '0;
    bus.req_op_high   = '0;
    bus.rsp_ready     = 2'b00;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_size_overflow();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cix32_muldiv_arb.md
CIX32_MULDIV_ARB -- requirements
Module: cix32_muldiv_arb

Interface
REQ-001 Parameter WDOG_CYCLES, 48, maximum cycles in WAIT before abort (range 40..63).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 req_valid input 2, per-requester request valid (bit 0 = pipeline, bit 1 = microcode).
REQ-004 req_ready output 2, per-requester request accept.
REQ-005 req_is_div, req_is_signed input 2 each, per-requester operation controls.
REQ-006 req_size input 2x2, per-requester operand size (00=32-bit, 01=16-bit, 10=8-bit, 11=reserved, treated as 32-bit).
REQ-007 req_op_a, req_op_b, req_op_high input 2x32 each, per-requester operands.
REQ-008 rsp_valid output 2, one-hot response valid; rsp_ready input 2, per-requester response accept.
REQ-009 rsp_result output 64, rsp_div_err / rsp_timeout / rsp_cf / rsp_of output 1 each, shared response payload.
REQ-010 md_start, md_is_div, md_is_signed, md_is_8bit, md_is_16bit output 1 each; md_op_a, md_op_b, md_op_high output 32 each, multiply/divide unit controls.
REQ-011 md_result input 64; md_ready, md_divide_error, md_cf, md_of input 1 each, multiply/divide unit status.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, GUARD, WAIT, RESP, DRAIN.
REQ-013 In IDLE, arbitration SHALL be round-robin: single valid requester wins; both valid -> requester other than last_grant wins.
REQ-014 req_ready[g] SHALL be 1 combinationally only in IDLE and only for the winner g; all other req_ready bits 0.
REQ-015 On handshake, requester id, controls and operands SHALL latch into internal registers; IDLE->ISSUE; last_grant <= g.
REQ-016 md_* operand/control outputs SHALL drive from latched registers and stay stable from ISSUE through DRAIN.
REQ-017 ISSUE: md_start=1 for exactly one cycle; ->GUARD.
REQ-018 GUARD: md_start=0; md_ready ignored; ->WAIT; watchdog counter cleared to 0.
REQ-019 WAIT: counter increments each cycle; md_ready=1 -> capture md_result, md_divide_error, md_cf, md_of into response registers, ->RESP.
REQ-020 WAIT: counter reaching WDOG_CYCLES without md_ready -> rsp_result=0, rsp_timeout=1, other flags 0, ->RESP.
REQ-021 md_ready and watchdog expiry in the same cycle SHALL resolve as normal completion (md_ready wins).
REQ-022 rsp_cf/rsp_of SHALL be forced 0 for divide operations; rsp_div_err SHALL be forced 0 for multiply operations.
REQ-023 RESP: rsp_valid[id]=1, payload stable, until rsp_ready[id]=1; rsp_ready on the non-owning bit SHALL be ignored.
REQ-024 RESP handshake -> DRAIN; DRAIN: md_start=1 one cycle (returns unit to its idle state), ->IDLE; no new grant in the DRAIN cycle.
REQ-025 Minimum latency, grant to rsp_valid: unit latency + 3 cycles; back-to-back throughput: one op per (unit latency + 5) cycles.
REQ-026 Changes on req_* inputs after handshake SHALL not affect an operation in flight.

Reset
REQ-027 rst SHALL force: state IDLE, last_grant=1 (requester 0 wins first tie), counter 0, md_start 0, req_ready 0 during reset, rsp_valid 0, rsp_result 0, all rsp flags 0, latched operands 0.
REQ-028 Reset asserted mid-operation SHALL abandon the op with no response issued; first post-reset grant follows REQ-027.

Verification
REQ-029 Req0 unsigned mul, size 00, a=7, b=6 -> md_start pulse, then rsp_valid=01, rsp_result=42, cf=0, of=0.
REQ-030 Req1 unsigned div, size 00, high=0, a=100, b=7 -> rsp_valid=10, rsp_result[31:0]=14, [63:32]=2, div_err=0.
REQ-031 Req0 div with b=0 -> md_divide_error=1 captured: rsp_div_err=1, rsp_timeout=0, rsp_valid=01.
REQ-032 Both req_valid held high for 4 ops from reset -> grant order 0,1,0,1; never two req_ready bits high.
REQ-033 Unit model never raises md_ready -> rsp_timeout=1 exactly WDOG_CYCLES cycles after GUARD, rsp_result=0.
REQ-034 rst pulsed during WAIT, then req1 only -> no stale rsp_valid; req1 granted, correct result returned; rsp_ready held low 10 cycles keeps payload stable.
